// File: rtl/skinny_sbox_serial_ctrl.sv
// skinny_sbox_serial_ctrl: serial 3-share masked S-box layer sequencer for a SKINNY-64 state.
// Latches three state shares on start and issues one nibble per cycle (nibble 0 first) to an
// external fixed-latency S-box pipeline whenever rnd_valid is high. Returned shares are written
// back in place, and done pulses once every nibble has returned.
// Ports: clk/rst_n (async active-low); start; state_in1..3; rnd_valid/rnd_req (PRNG handshake);
//        sb_in1..3 / sb_out1..3 (S-box pipeline); state_out1..3; busy; done.
// Option: SBOX_ZEROIZE_EN forces sb_in* to 0 on non-issue cycles and clears the input shares
//         on entering DONE.
module skinny_sbox_serial_ctrl #(
  parameter int NIBBLES = 16,
  parameter int LAT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_in1,
  input  logic [4*NIBBLES-1:0] state_in2,
  input  logic [4*NIBBLES-1:0] state_in3,
  input  logic                 rnd_valid,
  output logic                 rnd_req,
  output logic [3:0]           sb_in1,
  output logic [3:0]           sb_in2,
  output logic [3:0]           sb_in3,
  input  logic [3:0]           sb_out1,
  input  logic [3:0]           sb_out2,
  input  logic [3:0]           sb_out3,
  output logic [4*NIBBLES-1:0] state_out1,
  output logic [4*NIBBLES-1:0] state_out2,
  output logic [4*NIBBLES-1:0] state_out3,
  output logic                 busy,
  output logic                 done
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0][IW-1:0] tag_q, tag_d;
  logic [2:0][W-1:0] in_q, in_d, out_q, out_d;
  logic [2:0][3:0] sb_q, sb_d, nib, sb_o;
  logic busy_q, busy_d, done_q, done_d;
  logic issue, last;
  assign issue = st_q == ISSUE && rnd_valid;
  assign last  = idx_q == IW'(NIBBLES - 1);
  assign sb_o  = {sb_out3, sb_out2, sb_out1};
  // sb_q only ever loads on issue; in the zeroize build it stays 0, so non-issue cycles drive 0
  assign {sb_in3, sb_in2, sb_in1} = issue ? nib : sb_q;
  assign {state_out3, state_out2, state_out1} = out_q;
  assign busy    = busy_q;
  assign rnd_req = busy_q;
  assign done    = done_q;
  assign busy_d  = st_d == ISSUE || st_d == DRAIN;
  assign done_d  = st_d == DONE;
  always_comb begin
    for (int k = 0; k < 3; k++) nib[k] = in_q[k][idx_q*4 +: 4];
  end
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    in_d = in_q;
    out_d = out_q;
    sb_d = sb_q;
    vld_d[0] = issue;
    tag_d[0] = idx_q;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    // the tail entry lines up with the cycle its S-box result is on sb_out*
    if (vld_q[LAT-1])
      for (int k = 0; k < 3; k++) out_d[k][tag_q[LAT-1]*4 +: 4] = sb_o[k];
`ifndef SBOX_ZEROIZE_EN
    if (issue) sb_d = nib;
`endif
    case (st_q)
      IDLE: if (start) begin
        st_d = ISSUE;
        in_d = {state_in3, state_in2, state_in1};
        out_d = {state_in3, state_in2, state_in1};
      end
      ISSUE: if (issue) begin
        idx_d = last ? '0 : idx_q + IW'(1);
        st_d = last ? DRAIN : ISSUE;
      end
      DRAIN: if (vld_d == '0) begin
        st_d = DONE;
`ifdef SBOX_ZEROIZE_EN
        in_d = '0;
`endif
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      idx_q <= '0;
      vld_q <= '0;
      tag_q <= '0;
      in_q <= '0;
      out_q <= '0;
      sb_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      tag_q <= tag_d;
      in_q <= in_d;
      out_q <= out_d;
      sb_q <= sb_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
